// File: rtl/multicycle_control.sv
// Moore control sequencer for the multi-cycle MIPS datapath: fetch, decode, execute, memory, write-back.
// Optional jump support is built when MULTICYCLE_JUMP_EN is defined; otherwise opcode 0x02 is illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_eq_o,
  output logic       pc_write_cond_ne_o,
  output logic [1:0] pc_source_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_opcode_o
);

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXEC_R    = 4'd6;
  localparam logic [3:0] ST_WB_R      = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_EXEC_I    = 4'd10;
  localparam logic [3:0] ST_WB_I      = 4'd11;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [3:0] ST_JUMP      = 4'd9;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
`endif

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;

  typedef struct packed {
    logic       pc_write;
    logic       cond_eq;
    logic       cond_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctl_t;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dispatch;
  logic       opcode_legal;
  logic [3:0] out_state;
  ctl_t       ctl;
  ctl_t       ctl_out;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Opcode dispatch target out of DECODE; anything unrecognised retires as a no-op.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    dispatch     = ST_FETCH;
    opcode_legal = 1'b1;
    case (opcode_i)
      OP_RTYPE:        dispatch = ST_EXEC_R;
      OP_ADDI, OP_ORI: dispatch = ST_EXEC_I;
      OP_LW, OP_SW:    dispatch = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:  dispatch = ST_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
      OP_J:            dispatch = ST_JUMP;
`endif
      default:         opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = ST_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH:     state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        state_d   = dispatch;
        illegal_d = illegal_q | ~opcode_legal;
      end
      ST_MEM_ADDR: begin
        if (opcode_i == OP_LW)      state_d = ST_MEM_READ;
        else if (opcode_i == OP_SW) state_d = ST_MEM_WRITE;
        else                        state_d = ST_FETCH;
      end
      ST_MEM_READ:  state_d = mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_EXEC_R:    state_d = ST_WB_R;
      ST_EXEC_I:    state_d = ST_WB_I;
      default:      state_d = ST_FETCH;
    endcase
  end

  // While reset is held the outputs already present FETCH so no stale write escapes that cycle.
  assign out_state = reset ? ST_FETCH : state_q;

  always_comb begin
    ctl = '0;
    case (out_state)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.i_or_d    = 1'b0;
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PC_SRC_ALU;
        ctl.ir_write  = mem_ready_i;
        ctl.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctl.alu_src_a  = 1'b0;
        ctl.alu_src_b  = SRC_B_IMM_SH2;
        ctl.alu_op     = ALU_ADD;
        ctl.instr_done = ~opcode_legal;
      end
      ST_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = mem_ready_i;
      end
      ST_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_REG;
        ctl.alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        ctl.alu_op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      ST_WB_I: begin
        ctl.reg_dst    = 1'b0;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRC_B_REG;
        ctl.alu_op     = ALU_SUB;
        ctl.pc_source  = PC_SRC_ALUOUT;
        ctl.cond_eq    = (opcode_i == OP_BEQ);
        ctl.cond_ne    = (opcode_i == OP_BNE);
        ctl.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      ST_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_JUMP;
        ctl.instr_done = 1'b1;
      end
`endif
      default: ctl = '0;
    endcase
  end

  always_comb begin
    ctl_out = ctl;
    if (reset) begin
      ctl_out.pc_write   = 1'b0;
      ctl_out.cond_eq    = 1'b0;
      ctl_out.cond_ne    = 1'b0;
      ctl_out.ir_write   = 1'b0;
      ctl_out.mem_read   = 1'b0;
      ctl_out.mem_write  = 1'b0;
      ctl_out.reg_write  = 1'b0;
      ctl_out.instr_done = 1'b0;
    end
  end

  assign pc_write_o         = ctl_out.pc_write;
  assign pc_write_cond_eq_o = ctl_out.cond_eq;
  assign pc_write_cond_ne_o = ctl_out.cond_ne;
  assign pc_source_o        = ctl_out.pc_source;
  assign i_or_d_o           = ctl_out.i_or_d;
  assign mem_read_o         = ctl_out.mem_read;
  assign mem_write_o        = ctl_out.mem_write;
  assign ir_write_o         = ctl_out.ir_write;
  assign reg_dst_o          = ctl_out.reg_dst;
  assign mem_to_reg_o       = ctl_out.mem_to_reg;
  assign reg_write_o        = ctl_out.reg_write;
  assign alu_src_a_o        = ctl_out.alu_src_a;
  assign alu_src_b_o        = ctl_out.alu_src_b;
  assign alu_op_o           = ctl_out.alu_op;
  assign instr_done_o       = ctl_out.instr_done;
  assign state_o            = out_state;
  assign illegal_opcode_o   = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push expected state/control words,
// a negedge monitor pops and compares them.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       cond_eq;
    logic       cond_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       w;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = 6'h00;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o;
  logic [1:0] pc_source_o;
  logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       instr_done_o, illegal_opcode_o;

  exp_t sb[$];
  exp_t e_mon;
  exp_t a_mon;
  ctl_t act_w;
  logic exp_ill = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  multicycle_control dut (
    .clk                (clk),
    .reset              (reset),
    .opcode_i           (opcode_i),
    .mem_ready_i        (mem_ready_i),
    .pc_write_o         (pc_write_o),
    .pc_write_cond_eq_o (pc_write_cond_eq_o),
    .pc_write_cond_ne_o (pc_write_cond_ne_o),
    .pc_source_o        (pc_source_o),
    .i_or_d_o           (i_or_d_o),
    .mem_read_o         (mem_read_o),
    .mem_write_o        (mem_write_o),
    .ir_write_o         (ir_write_o),
    .reg_dst_o          (reg_dst_o),
    .mem_to_reg_o       (mem_to_reg_o),
    .reg_write_o        (reg_write_o),
    .alu_src_a_o        (alu_src_a_o),
    .alu_src_b_o        (alu_src_b_o),
    .alu_op_o           (alu_op_o),
    .state_o            (state_o),
    .instr_done_o       (instr_done_o),
    .illegal_opcode_o   (illegal_opcode_o)
  );

  always #5 clk = ~clk;

  assign act_w = {pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, pc_source_o, i_or_d_o,
                  mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o};

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05: return 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      6'h02: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Hand transcription of the per-state output table.
  function automatic ctl_t spec_word(input logic [3:0] st, input logic [5:0] op,
                                     input logic mr, input logic rst);
    ctl_t w;
    w = '0;
    if (rst) begin
      w.alu_src_b = 2'b01;
      return w;
    end
    case (st)
      4'd0:  begin w.mem_read = 1; w.alu_src_b = 2'b01; w.ir_write = mr; w.pc_write = mr; end
      4'd1:  begin w.alu_src_b = 2'b11; w.instr_done = !is_legal(op); end
      4'd2:  begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      4'd3:  begin w.mem_read = 1; w.i_or_d = 1; end
      4'd4:  begin w.mem_to_reg = 1; w.reg_write = 1; w.instr_done = 1; end
      4'd5:  begin w.mem_write = 1; w.i_or_d = 1; w.instr_done = mr; end
      4'd6:  begin w.alu_src_a = 1; w.alu_op = 3'b010; end
      4'd7:  begin w.reg_dst = 1; w.reg_write = 1; w.instr_done = 1; end
      4'd8:  begin
        w.alu_src_a = 1; w.alu_op = 3'b001; w.pc_source = 2'b01; w.instr_done = 1;
        w.cond_eq = (op == 6'h04); w.cond_ne = (op == 6'h05);
      end
      4'd9:  begin w.pc_write = 1; w.pc_source = 2'b10; w.instr_done = 1; end
      4'd10: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_op = (op == 6'h0D) ? 3'b011 : 3'b000; end
      4'd11: begin w.reg_write = 1; w.instr_done = 1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b0; opcode_i = op; mem_ready_i = mr;
    e = '{st: st, w: spec_word(st, op, mr, 1'b0), ill: exp_ill};
    sb.push_back(e);
  endtask

  task automatic rst_cyc(input logic [5:0] op, input logic mr);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1; opcode_i = op; mem_ready_i = mr;
    exp_ill = 1'b0;
    e = '{st: 4'd0, w: spec_word(4'd0, op, mr, 1'b1), ill: 1'b0};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      a_mon = '{st: state_o, w: act_w, ill: illegal_opcode_o};
      n_checks++;
      if (a_mon !== e_mon) begin
        n_fail++;
        $display("FAIL cycle_check #%0d t=%0t: got state=%0d ctl=%h ill=%b, expected state=%0d ctl=%h ill=%b",
                 n_checks, $time, a_mon.st, a_mon.w, a_mon.ill, e_mon.st, e_mon.w, e_mon.ill);
      end
    end
  end

  initial begin
    // Reset with mem_ready high: FETCH strobes must stay quiet.
    rst_cyc(6'h00, 1'b1);
    rst_cyc(6'h00, 1'b1);
    // R-type
    cyc(6'h00, 1, 4'd0); cyc(6'h00, 1, 4'd1); cyc(6'h00, 1, 4'd6); cyc(6'h00, 1, 4'd7);
    // lw, two wait cycles in MEM_READ
    cyc(6'h23, 1, 4'd0); cyc(6'h23, 1, 4'd1); cyc(6'h23, 1, 4'd2);
    cyc(6'h23, 0, 4'd3); cyc(6'h23, 0, 4'd3); cyc(6'h23, 1, 4'd3); cyc(6'h23, 1, 4'd4);
    // addi, ori
    cyc(6'h08, 1, 4'd0); cyc(6'h08, 1, 4'd1); cyc(6'h08, 1, 4'd10); cyc(6'h08, 1, 4'd11);
    cyc(6'h0D, 1, 4'd0); cyc(6'h0D, 1, 4'd1); cyc(6'h0D, 1, 4'd10); cyc(6'h0D, 1, 4'd11);
    // sw with a FETCH wait and a MEM_WRITE wait
    cyc(6'h2B, 0, 4'd0); cyc(6'h2B, 1, 4'd0); cyc(6'h2B, 1, 4'd1); cyc(6'h2B, 1, 4'd2);
    cyc(6'h2B, 0, 4'd5); cyc(6'h2B, 1, 4'd5);
    // beq, bne
    cyc(6'h04, 1, 4'd0); cyc(6'h04, 1, 4'd1); cyc(6'h04, 1, 4'd8);
    cyc(6'h05, 1, 4'd0); cyc(6'h05, 1, 4'd1); cyc(6'h05, 1, 4'd8);
    // jump
`ifdef MULTICYCLE_JUMP_EN
    cyc(6'h02, 1, 4'd0); cyc(6'h02, 1, 4'd1); cyc(6'h02, 1, 4'd9);
`else
    cyc(6'h02, 1, 4'd0); cyc(6'h02, 1, 4'd1);
    exp_ill = 1'b1;
`endif
    // Illegal opcode: flag visible from the cycle after DECODE, sticky afterwards
    cyc(6'h3F, 1, 4'd0); cyc(6'h3F, 1, 4'd1);
    exp_ill = 1'b1;
    // R-type with mem_ready low where it must be ignored
    cyc(6'h00, 1, 4'd0); cyc(6'h00, 0, 4'd1); cyc(6'h00, 0, 4'd6); cyc(6'h00, 0, 4'd7);
    // Reset in the middle of a stalled MEM_WRITE
    cyc(6'h2B, 1, 4'd0); cyc(6'h2B, 1, 4'd1); cyc(6'h2B, 1, 4'd2);
    cyc(6'h2B, 0, 4'd5); cyc(6'h2B, 0, 4'd5);
    rst_cyc(6'h2B, 1'b0);
    cyc(6'h00, 1, 4'd0); cyc(6'h00, 1, 4'd1); cyc(6'h00, 1, 4'd6); cyc(6'h00, 1, 4'd7);
    cyc(6'h00, 0, 4'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control sequencer for a multi-cycle build of the MIPS datapath. A single ALU, a single unified memory port and an instruction register replace the separate adders and program/data memories of the single-cycle core. The block decodes the opcode held in the IR and steps the datapath through fetch, decode, execute, memory and write-back. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; state returns to FETCH.
- opcode_i  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_eq_o / pc_write_cond_ne_o  out  1 each  PC load if ALU zero is 1 / 0.
- pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d_o  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read_o, mem_write_o, ir_write_o  out  1 each  memory/IR strobes.
- reg_dst_o  out  1  0 rt, 1 rd.
- mem_to_reg_o  out  1  write-back: 0 ALUOut, 1 MDR.
- reg_write_o  out  1  register-file write.
- alu_src_a_o  out  1  0 PC, 1 reg A.
- alu_src_b_o  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op_o  out  3  000 add, 001 sub, 010 funct-decoded, 011 or.
- state_o  out  4  current state encoding.
- instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_opcode_o  out  1  sticky flag; cleared only by reset.

## Operation
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, EXEC_I 10, WB_I 11. Codes 12–15 recover to FETCH on the next cycle.
- Outputs are decoded from the state only, except strobes gated by mem_ready_i as noted. All outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=add, pc_source=00.
  - ir_write = pc_write = mem_ready_i.
  - Stays in FETCH until mem_ready_i, then goes to DECODE.
- DECODE:
  - Outputs: src_a=0, src_b=11, alu_op=add (branch target into ALUOut).
  - Dispatch on opcode: 0x00→EXEC_R; 0x08, 0x0D→EXEC_I; 0x23, 0x2B→MEM_ADDR; 0x04, 0x05→BRANCH; 0x02→JUMP (see Configuration).
  - Any other opcode: set illegal_opcode_o, pulse instr_done_o, go to FETCH (executes as a no-op).
- MEM_ADDR: src_a=1, src_b=10, add. Goes to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done. Then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, held for the whole wait. On mem_ready_i: instr_done, then FETCH.
- EXEC_R: src_a=1, src_b=00, alu_op=010. Then WB_R.
- WB_R: reg_dst=1, reg_write=1, instr_done. Then FETCH.
- EXEC_I: src_a=1, src_b=10, alu_op=add for 0x08, or for 0x0D. Then WB_I.
- WB_I: reg_dst=0, reg_write=1, instr_done. Then FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=sub, pc_source=01. cond_eq=1 for 0x04, cond_ne=1 for 0x05. instr_done. Then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done. Then FETCH.

## Timing
- Reset value while reset=1: state FETCH, illegal_opcode_o=0, and every strobe forced to 0 (pc_write, cond_eq, cond_ne, ir_write, mem_read, mem_write, reg_write, instr_done). Select outputs take their FETCH values.
- Latency with mem_ready_i tied high:
  - R-type, I-ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - beq/bne, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle mem_ready_i is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. Address, strobes and selects hold stable throughout the wait.
- mem_ready_i is ignored in all other states.
- Reset asserted mid-instruction aborts it. No write strobe is issued in the reset cycle, and FETCH resumes on the first cycle after reset deasserts.
- The illegal flag sets on the clock edge leaving DECODE and is visible in the following cycle.

## Configuration
- MULTICYCLE_JUMP_EN defined: opcode 0x02 goes to JUMP as specified.
- MULTICYCLE_JUMP_EN undefined: the JUMP state is not built, 0x02 is handled as an illegal opcode, and code 9 recovers to FETCH.

## Test plan
- mem_ready=1, opcode 0x00 → state sequence 0,1,6,7,0. reg_dst=1 and reg_write=1 in cycle 4 only. instr_done pulses once.
- opcode 0x23, mem_ready low for 2 cycles in MEM_READ → sequence 0,1,2,3,3,3,4,0 (7 cycles). mem_read and i_or_d=1 held through the wait. mem_to_reg=1 in state 4.
- opcode 0x05 → sequence 0,1,8,0. In state 8: cond_ne=1, cond_eq=0, alu_op=001, pc_source=01. pc_write=0 throughout except FETCH.
- opcode 0x3F → sequence 0,1,0. illegal_opcode_o=1 from cycle 3 and stays 1 across following valid instructions until reset.
- reset asserted while in MEM_WRITE with mem_ready=0 → next cycle state=0, mem_write=0, reg_write=0. mem_write never pulses.
- opcode 0x02 → with MULTICYCLE_JUMP_EN: sequence 0,1,9,0, with pc_source=10 and pc_write=1 in state 9. Without it: sequence 0,1,0 and the illegal flag sets.
